// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: FSM state encoding,
// request size encodings, the memory word width and the request legality check.
package dmem_access_unit_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // A request is rejected when its size is the reserved encoding or when
    // the address is not naturally aligned for the access size.
    function automatic logic is_req_err(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// dmem_lane_align: combinational little-endian lane logic shared by the load
// and store paths.
//   word      : captured memory word
//   wdata     : right-aligned store data
//   size      : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset    : byte address bits [1:0]
//   sign_ext  : replicate lane MSB on sub-word loads
//   load_data : addressed lane, right-aligned and extended
//   merged    : word with the addressed lane replaced by wdata (read-modify-write)
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Byte k sits at bits [8k+7:8k]; halfword selected by offset[1].
    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
            SZ_HALF: load_data = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: turns byte/halfword/word load-store requests into
// word-aligned data-memory accesses. Sub-word stores use read-modify-write.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake
//   req_write/size/signed/addr/wdata: request fields, registered at acceptance
//   resp_valid/resp_ready           : response handshake
//   resp_rdata, resp_err            : load result (0 for stores/errors), error flag
//   memRead, memWrite, address      : memory strobes and word-aligned address
//   dmem_in, dmem_out               : memory write data, registered read data
module dmem_access_unit #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dmem_in,
    input  logic [DATA_W-1:0] dmem_out
);
    import dmem_access_unit_pkg::*;

    state_t            state, state_nxt;
    logic              write_q, signed_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, word_q;
    logic [DATA_W-1:0] load_data, merged;
    logic              req_err;

    assign req_err = is_req_err(req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)                               state_nxt = RESP;
                    else if (req_write && req_size == SZ_WORD) state_nxt = WR;
                    else                                       state_nxt = RD;
                end
            end
            RD:      state_nxt = RD_CAP;
            // Sub-word stores continue to the merge write; loads go straight to RESP.
            RD_CAP:  state_nxt = write_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers carry no reset: every output that exposes them is
    // gated by the state, which is reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
        end
        // Memory registered the read at the RD edge, so dmem_out is valid now.
        if (state == RD_CAP) word_q <= dmem_out;
    end

    dmem_lane_align u_lane_align (
        .word      (word_q),
        .wdata     (wdata_q),
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .sign_ext  (signed_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // rst_n gates req_ready so it reads 0 while reset is held.
    assign req_ready  = rst_n && (state == IDLE);
    assign memRead    = (state == RD);
    assign memWrite   = (state == WR);
    assign address    = (state == RD || state == WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_in    = (state == WR) ? merged : '0;
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP && !err_q && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a small registered memory model.
module tb_dmem_access_unit;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              req_ready, resp_valid, resp_err, memRead, memWrite;
    logic              resp_ready = 1'b0;
    logic [31:0]       resp_rdata, dmem_in;
    logic [31:0]       dmem_out = '0;
    logic [ADDR_W-1:0] address;
    logic              preload = 1'b1;
    logic [31:0]       mem [0:31];

    int n_cmp = 0;
    int n_fail = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .memRead(memRead),
        .memWrite(memWrite), .address(address), .dmem_in(dmem_in), .dmem_out(dmem_out)
    );

    // Memory: registers read data on a memRead edge, zero otherwise.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h0000000A;
            mem[1] <= 32'hFFFFFFD1;
            dmem_out <= 32'h0;
        end else begin
            dmem_out <= memRead ? mem[address[6:2]] : 32'h0;
            if (memWrite) mem[address[6:2]] <= dmem_in;
        end
    end

    always @(negedge clk) if (memRead && memWrite) both_cnt++;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [6:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic sgn, logic [6:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee, int lat,
                                int rd, int wrn, logic [6:0] wa, logic [31:0] wdx);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd;
        v.exp_wr = wrn; v.exp_waddr = wa; v.exp_wdata = wdx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input string tag);
        exp_t e, got;
        int lat, rdc, wrc;
        logic [6:0] wa;
        logic [31:0] wd;
        bit seen;
        @(negedge clk);
        chk($sformatf("%s.req_ready", tag), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        e.rd = v.exp_rd; e.wr = v.exp_wr;
        sb.push_back(e);
        lat = 0; rdc = 0; wrc = 0; wa = '0; wd = '0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (memRead) rdc++;
            if (memWrite) begin wrc++; wa = address; wd = dmem_in; end
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL %s.timeout: no resp_valid within 20 cycles", tag);
            sb.delete();
            return;
        end
        got = sb.pop_front();
        chk($sformatf("%s.rdata", tag), resp_rdata, got.rdata);
        chk($sformatf("%s.err", tag), 32'(resp_err), 32'(got.err));
        chk($sformatf("%s.latency", tag), 32'(lat), 32'(got.lat));
        chk($sformatf("%s.rd_pulses", tag), 32'(rdc), 32'(got.rd));
        chk($sformatf("%s.wr_pulses", tag), 32'(wrc), 32'(got.wr));
        if (v.exp_wr > 0) begin
            chk($sformatf("%s.waddr", tag), 32'(wa), 32'(v.exp_waddr));
            chk($sformatf("%s.wdata", tag), wd, v.exp_wdata);
        end
        chk($sformatf("%s.ready_in_resp", tag), 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        int pulses;
        bit seen;
        //  wr  sz     sgn addr   wdata          exp_rdata      err lat rd wr waddr  wdata
        vecs.push_back(mk(0, 2'b10, 0, 7'h04, 32'h0,        32'hFFFFFFD1, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 7'h04, 32'h0,        32'hFFFFFFD1, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 7'h05, 32'h0,        32'h000000FF, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 7'h00, 32'h0,        32'h0000000A, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 7'h01, 32'h0000005A, 32'h0,        0, 4, 1, 1, 7'h00, 32'h00005A0A));
        vecs.push_back(mk(0, 2'b10, 0, 7'h00, 32'h0,        32'h00005A0A, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 7'h06, 32'h0,        32'h0,        1, 1, 0, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 7'h00, 32'h0,        32'h0,        1, 1, 0, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 2'b10, 0, 7'h08, 32'h12345678, 32'h0,        0, 2, 0, 1, 7'h08, 32'h12345678));
        vecs.push_back(mk(0, 2'b01, 1, 7'h0A, 32'h0,        32'h00001234, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 7'h06, 32'h0,        32'hFFFFFFFF, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 7'h06, 32'h0,        32'h0000FFFF, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 7'h0A, 32'h0000BEEF, 32'h0,        0, 4, 1, 1, 7'h08, 32'hBEEF5678));
        vecs.push_back(mk(0, 2'b10, 0, 7'h08, 32'h0,        32'hBEEF5678, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b00, 0, 7'h0B, 32'h0,        32'h000000BE, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 7'h0B, 32'h0,        32'hFFFFFFBE, 0, 3, 1, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 7'h09, 32'h00001111, 32'h0,        1, 1, 0, 0, 7'h00, 32'h0));
        vecs.push_back(mk(1, 2'b00, 0, 7'h07, 32'h123456AB, 32'h0,        0, 4, 1, 1, 7'h04, 32'hABFFFFD1));
        vecs.push_back(mk(0, 2'b10, 1, 7'h04, 32'h0,        32'hABFFFFD1, 0, 3, 1, 0, 7'h00, 32'h0));

        // Reset state, with a request offered while reset is held.
        req_valid = 1'b1;
        #2;
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.strobes", {30'd0, memRead, memWrite}, 32'd0);
        chk("rst.address", 32'(address), 32'd0);
        chk("rst.dmem_in", dmem_in, 32'd0);
        repeat (2) @(posedge clk);
        #1 preload = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], $sformatf("v%0d", i));

        // Reset pulse during RD_CAP of a load aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 7'h00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort.rd_strobe", 32'(memRead), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.strobes_low", {30'd0, memRead, memWrite}, 32'd0);
        chk("abort.resp_valid", 32'(resp_valid), 32'd0);
        chk("abort.ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort.ready_after", 32'(req_ready), 32'd1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || memRead || memWrite) pulses++;
        end
        chk("abort.no_activity", 32'(pulses), 32'd0);
        chk("abort.sb_empty", 32'(sb.size()), 32'd0);

        // Response backpressure with a competing request held on the input.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 7'h00;
        @(posedge clk);
        #1 req_addr = 7'h04;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("bp.resp_seen", 32'(seen), 32'd1);
        chk("bp.rdata", resp_rdata, 32'h00005A0A);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d.valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp.hold%0d.rdata", c), resp_rdata, 32'h00005A0A);
            chk($sformatf("bp.hold%0d.ready", c), 32'(req_ready), 32'd0);
            if (memRead || memWrite) pulses++;
        end
        chk("bp.no_mem_activity", 32'(pulses), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_after_consume", 32'(req_ready), 32'd1);
        chk("bp.not_accepted", 32'(memRead), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        chk("never_dual_strobe", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
